// File: rtl/kuznechik_pkg.sv
// Shared types, constants and GF(2^8) helpers for the Kuznechik linear layer.
package kuznechik_pkg;

  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned NUM_BYTES = 16;

  // Low byte of the field polynomial x^8+x^7+x^6+x+1.
  localparam logic [7:0] GF_POLY = 8'hC3;

  // Index 0 multiplies a15 (the top byte), index 15 multiplies a0.
  localparam logic [7:0] L_COEF [0:NUM_BYTES-1] = '{
    8'd148, 8'd32,  8'd133, 8'd16, 8'd194, 8'd192, 8'd1,   8'd251,
    8'd1,   8'd192, 8'd194, 8'd16, 8'd133, 8'd32,  8'd148, 8'd1
  };

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Shift-and-add multiply; with a constant coef this folds to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] coef);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (coef[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] l_fn(input block_t a);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      acc = acc ^ gf_mul(a[8*(NUM_BYTES-1-i) +: 8], L_COEF[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/kuznechik_r_round.sv
// One combinational R (inv=0) or R^-1 (inv=1) round on a 128-bit block.
module kuznechik_r_round
  import kuznechik_pkg::*;
(
  input  block_t blk,
  input  logic   inv,
  output block_t res_c
);

  // Inverse feeds l with a14..a0 followed by a15 in the a0 slot.
  block_t rot;
  assign rot = {blk[BLOCK_W-9:0], blk[BLOCK_W-1 -: 8]};

  always_comb begin
    res_c = {l_fn(blk), blk[BLOCK_W-1:8]};
    if (inv) res_c = {blk[BLOCK_W-9:0], l_fn(rot)};
  end

endmodule

// File: rtl/kuznechik_l_engine.sv
// Iterative L / L^-1 engine: ROUNDS_PER_CYCLE chained rounds per clock, handshake in and out.
module kuznechik_l_engine
  import kuznechik_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  logic   in_mode,
  input  block_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output block_t out_data,
  output logic   busy
);

  localparam int unsigned ITER  = NUM_BYTES / ROUNDS_PER_CYCLE;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
    $error("kuznechik_l_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e           state;
  block_t           state_reg;
  logic             mode_reg;
  logic [CNT_W-1:0] cnt;
  logic             last;

  // Round chain evaluated from the current state each RUN cycle.
  block_t chain [0:ROUNDS_PER_CYCLE];
  assign chain[0] = state_reg;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    kuznechik_r_round u_round (
      .blk   (chain[g]),
      .inv   (mode_reg),
      .res_c (chain[g+1])
    );
  end

  assign last = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      state_reg <= '0;
      mode_reg  <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state_reg <= in_data;
            mode_reg  <= in_mode;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          state_reg <= chain[ROUNDS_PER_CYCLE];
          cnt       <= last ? '0 : cnt + CNT_W'(1);
          if (last) begin
            out_data  <= chain[ROUNDS_PER_CYCLE];
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kuznechik_l_engine.sv
// Directed + random bench: standalone round, and engines at every legal unroll factor.
module tb_kuznechik_l_engine;
  import kuznechik_pkg::*;

  localparam int NI = 5;

  localparam block_t VEC_PT = 128'h64a59400000000000000000000000000;
  localparam block_t VEC_CT = 128'hd456584dd0e3e84cc3166e4b7fa2890d;

  // Coefficient for byte position p (p = 0 is a0).
  localparam logic [7:0] REF_C [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  logic   in_mode = 1'b0;
  logic   out_ready = 1'b1;
  block_t in_data = '0;

  logic   in_ready_a  [NI];
  logic   out_valid_a [NI];
  logic   busy_a      [NI];
  block_t out_data_a  [NI];

  block_t r_blk = '0;
  logic   r_inv = 1'b0;
  block_t r_res;

  int total = 0;
  int bad = 0;

  int     first_c [NI];
  block_t first_d [NI];
  int     busy_c  [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    kuznechik_l_engine #(.ROUNDS_PER_CYCLE(32'(1) << k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a[k]),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid_a[k]),
      .out_ready (out_ready),
      .out_data  (out_data_a[k]),
      .busy      (busy_a[k])
    );
  end

  kuznechik_r_round u_round (
    .blk   (r_blk),
    .inv   (r_inv),
    .res_c (r_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-less product then reduction by the full 9-bit polynomial.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int j = 14; j >= 8; j--) if (p[j]) p = p ^ (15'(9'h1C3) << (j - 8));
    return p[7:0];
  endfunction

  function automatic block_t ref_l(input block_t x);
    block_t s;
    logic [7:0] acc;
    s = x;
    for (int r = 0; r < 16; r++) begin
      acc = '0;
      for (int p = 0; p < 16; p++) acc = acc ^ ref_mul(s[8*p +: 8], REF_C[p]);
      s = {acc, s[127:8]};
    end
    return s;
  endfunction

  // Present one block with out_ready high; record per-engine latency, result and busy cycles.
  task automatic run_block(input block_t d, input logic m);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_mode  = ~m;
    for (int k = 0; k < NI; k++) begin
      first_c[k] = 0;
      first_d[k] = '0;
      busy_c[k]  = 0;
    end
    for (int c = 1; c <= 20; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (busy_a[k]) busy_c[k]++;
        if (out_valid_a[k] && first_c[k] == 0) begin
          first_c[k] = c;
          first_d[k] = out_data_a[k];
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_block(input string tag, input block_t exp);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_data_r%0d", tag, 1 << k), first_d[k], exp);
      check($sformatf("%s_lat_r%0d", tag, 1 << k), 128'(first_c[k]), 128'((16 >> k) + 1));
      check($sformatf("%s_busy_r%0d", tag, 1 << k), 128'(busy_c[k]), 128'(16 >> k));
      check($sformatf("%s_rdy_r%0d", tag, 1 << k), 128'(in_ready_a[k]), 128'(1));
    end
  endtask

  initial begin
    block_t x;
    block_t y;

    // Standalone round, both directions.
    r_inv = 1'b0; r_blk = 128'h00000000000000000000000000000100; #1;
    check("r_fwd1", r_res, 128'h94000000000000000000000000000001);
    r_blk = 128'h94000000000000000000000000000001; #1;
    check("r_fwd2", r_res, 128'ha5940000000000000000000000000000);
    r_blk = 128'ha5940000000000000000000000000000; #1;
    check("r_fwd3", r_res, 128'h64a59400000000000000000000000000);
    r_inv = 1'b1; r_blk = 128'h94000000000000000000000000000001; #1;
    check("r_inv1", r_res, 128'h00000000000000000000000000000100);
    r_blk = 128'h64a59400000000000000000000000000; #1;
    check("r_inv3", r_res, 128'ha5940000000000000000000000000000);

    // Reset values while rst is held, then in_ready after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid_r%0d", 1 << k), 128'(out_valid_a[k]), 128'(0));
      check($sformatf("rst_busy_r%0d", 1 << k), 128'(busy_a[k]), 128'(0));
      check($sformatf("rst_rdy_r%0d", 1 << k), 128'(in_ready_a[k]), 128'(0));
      check($sformatf("rst_data_r%0d", 1 << k), out_data_a[k], 128'(0));
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++)
      check($sformatf("post_rst_rdy_r%0d", 1 << k), 128'(in_ready_a[k]), 128'(1));

    run_block(VEC_PT, 1'b0);
    check_block("fwd", VEC_CT);
    run_block(VEC_CT, 1'b1);
    check_block("inv", VEC_PT);

    // Backpressure: result held stable in DONE.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = VEC_PT; in_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    repeat (16) @(negedge clk);
    check("bp_lat_valid", 128'(out_valid_a[0]), 128'(1));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), 128'(out_valid_a[0]), 128'(1));
      check($sformatf("bp_data_%0d", i), out_data_a[0], VEC_CT);
      check($sformatf("bp_rdy_%0d", i), 128'(in_ready_a[0]), 128'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("bp_rel_rdy_r%0d", 1 << k), 128'(in_ready_a[k]), 128'(1));
      check($sformatf("bp_rel_valid_r%0d", 1 << k), 128'(out_valid_a[k]), 128'(0));
    end

    // Reset while the single-round engine is at cnt = 5.
    @(negedge clk);
    in_valid = 1'b1; in_data = VEC_CT; in_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before", 128'(busy_a[0]), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_valid", 128'(out_valid_a[0]), 128'(0));
    check("mid_busy", 128'(busy_a[0]), 128'(0));
    check("mid_rdy_in_rst", 128'(in_ready_a[0]), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rdy_after", 128'(in_ready_a[0]), 128'(1));
    check("mid_valid_after", 128'(out_valid_a[0]), 128'(0));
    run_block(VEC_PT, 1'b0);
    check_block("mid_fwd", VEC_CT);

    // Random round trips against an independent model.
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = ref_l(x);
      run_block(x, 1'b0);
      check_block($sformatf("rt_fwd_%0d", n), y);
      run_block(y, 1'b1);
      check_block($sformatf("rt_inv_%0d", n), x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kuznechik_l_engine.md
Name: kuznechik_l_engine

Overview:
- Iterative engine for the GOST R 34.12-2015 (Kuznechik) linear transform L = R^16, or its inverse L^-1 = (R^-1)^16, on one 128-bit block.
- Parametrised successor to the single-byte L conversion table. Adds a full-block datapath, configurable unrolling, a forward/inverse mode and valid/ready handshakes on both sides.
- Sits between the S-box layer and the round-key XOR in the cipher round pipeline.

Parameters:
- ROUNDS_PER_CYCLE, 1, number of R (or R^-1) rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error.
- ITER, 16/ROUNDS_PER_CYCLE, derived, not overridable: number of busy cycles per block.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data and in_mode are valid this cycle.
- in_ready  out  1  engine can accept a block.
- in_mode  in  1  0 = forward L, 1 = inverse L^-1.
- in_data  in  128  input block. Byte a15 is [127:120]; byte a0 is [7:0].
- out_valid  out  1  out_data holds a finished block.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  transformed block, same byte order as in_data.
- busy  out  1  high while in state RUN.

Behaviour:
- Field arithmetic: GF(2^8) with polynomial x^8+x^7+x^6+x+1 (0x1C3).
- l(a15..a0) = 148*a15 + 32*a14 + 133*a13 + 16*a12 + 194*a11 + 192*a10 + 1*a9 + 251*a8 + 1*a7 + 192*a6 + 194*a5 + 16*a4 + 133*a3 + 32*a2 + 148*a1 + 1*a0. Addition is XOR.
- Forward round: R(a) = l(a15..a0) || a15..a1. The new byte l is placed at [127:120] and the state shifts right by one byte.
- Inverse round: R^-1(a) = a14..a0 || l(a14..a0, a15). The state shifts left by one byte and the new low byte is l computed with a15 in the a0 position.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1.
    - On in_valid && in_ready: state_reg <= in_data, mode_reg <= in_mode, cnt <= 0, go to RUN.
  - RUN: each cycle, state_reg <= ROUNDS_PER_CYCLE chained rounds in the direction given by mode_reg, and cnt <= cnt + 1.
    - When cnt == ITER-1, take that last update and go to DONE.
    - in_ready = 0 and busy = 1 throughout RUN.
  - DONE: out_valid = 1 and out_data = state_reg. Both stay stable until out_ready.
    - On out_ready: go to IDLE.
    - Back-to-back acceptance is not supported: in_ready stays 0 in DONE.
- Latency: ITER + 1 cycles from the in_valid accept edge to the first cycle out_valid is high. For ROUNDS_PER_CYCLE = 1 this is 17 cycles; for 16 it is 2 cycles.
- Throughput: one block per ITER + 2 cycles when out_ready is held high.
- cnt width is clog2(ITER), minimum 1 bit. cnt does not wrap inside a block.
- Reset values:
  - state goes to IDLE.
  - in_ready = 1 in the first cycle after rst is released.
  - out_valid = 0, busy = 0.
  - out_data = 0, state_reg = 0, cnt = 0, mode_reg = 0.
- Reset mid-operation (rst high in RUN or DONE): the block in flight is discarded and the engine is in IDLE on the next cycle. No out_valid pulse is produced for that block.
- While rst is high: in_valid is ignored and in_ready is driven 0.
- in_mode and in_data are sampled only on the accept edge. Changes at any other time have no effect.
- Registered outputs only. There is no combinational path from in_* to out_*.

Decomposition:
- Package kuznechik_pkg holds:
  - GF_POLY = 8'hC3 (low byte of 0x1C3).
  - L_COEF[0:15] = {148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1}, indexed from a15 down to a0.
  - function gf_mul(byte, byte), synthesising to constant multipliers.
  - typedef block_t = logic [127:0].
- One sub-module: kuznechik_r_round. It is combinational, takes a block and a mode, and returns R or R^-1 of that block.
  - The engine instantiates ROUNDS_PER_CYCLE copies in a chain.
  - Verification tests it standalone.

Test Plan:
- Single forward round, ROUNDS_PER_CYCLE = 1, observing state_reg after the first RUN cycle: in_data = 00000000000000000000000000000100 -> 94000000000000000000000000000001. One cycle later the state is a5940000000000000000000000000000.
- Full forward, each legal ROUNDS_PER_CYCLE: in_data = 64a59400000000000000000000000000, mode 0 -> out_data = d456584dd0e3e84cc3166e4b7fa2890d. out_valid rises exactly ITER + 1 cycles after accept.
- Full inverse: in_data = d456584dd0e3e84cc3166e4b7fa2890d, mode 1 -> out_data = 64a59400000000000000000000000000.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid stays 1, out_data stays stable, in_ready stays 0. Then out_ready = 1 -> IDLE with in_ready = 1 on the next cycle.
- Reset mid-RUN: assert rst at cnt = 5 -> next cycle is IDLE with out_valid = 0. A following block (64a594..00, mode 0) returns the correct d456584d...890d.
- Round trip: 1000 random blocks, forward then inverse -> each output equals the original input, with busy high for exactly ITER cycles per block.
